// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Shift-add multiply and restoring divide share one 2*DATA_W accumulator:
// the upper half holds the partial product or remainder, the lower half holds
// the multiplier or quotient.
// Optional feature macro MULDIV_EARLY_EXIT_EN: when b=0 the unit skips the
// iteration phase and writes the result one edge after start.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, op, a, b   operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we      MTHI/MTLO strobes, honoured only while idle
//   wdata             MTHI/MTLO data
//   busy              operation in progress
//   done              one-cycle pulse when HI/LO hold a new result
//   div_by_zero       pulses with done for DIV/DIVU with b=0
//   hi, lo            HI/LO registers
module muldiv_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_d;
    logic                accept_c;
    logic                iter_c;
    logic                finish_c;

    logic [CNT_W-1:0]    cnt;
    logic [1:0]          op_q;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] acc;

    // Operand magnitudes; only MULT/DIV (op[0]=0) treat operands as signed
    logic                signed_op_c;
    logic                a_neg_c;
    logic                b_neg_c;
    logic [DATA_W-1:0]   a_abs_c;
    logic [DATA_W-1:0]   b_abs_c;

    assign signed_op_c = ~op[0];
    assign a_neg_c     = signed_op_c & a[DATA_W-1];
    assign b_neg_c     = signed_op_c & b[DATA_W-1];
    assign a_abs_c     = a_neg_c ? -a : a;
    assign b_abs_c     = b_neg_c ? -b : b;

    // One multiply step: conditional add of the multiplicand, then shift right
    logic [DATA_W:0]     add_c;
    logic [2*DATA_W-1:0] mul_next_c;

    assign add_c      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_next_c = {add_c, acc[DATA_W-1:1]};

    // One restoring-divide step: shift the next dividend bit into the remainder
    logic [DATA_W:0]     shifted_c;
    logic [DATA_W:0]     diff_c;
    logic                fits_c;
    logic [2*DATA_W-1:0] div_next_c;

    assign shifted_c  = acc[2*DATA_W-1:DATA_W-1];
    assign diff_c     = shifted_c - {1'b0, b_q};
    assign fits_c     = shifted_c >= {1'b0, b_q};
    assign div_next_c = fits_c ? {diff_c[DATA_W-1:0], acc[DATA_W-2:0], 1'b1}
                               : {acc[2*DATA_W-2:0], 1'b0};

    // Sign fix-up and divide-by-zero substitution applied on the result-write edge
    logic [2*DATA_W-1:0] prod_c;
    logic [DATA_W-1:0]   hi_res_c;
    logic [DATA_W-1:0]   lo_res_c;

    always_comb begin
        prod_c   = acc;
        hi_res_c = acc[2*DATA_W-1:DATA_W];
        lo_res_c = acc[DATA_W-1:0];
        if (op_q == 2'b00 && (sign_a ^ sign_b)) begin
            prod_c = -acc;
        end
        // Covers the early-exit path, where the accumulator was never iterated
        if (b_q == '0) begin
            prod_c = '0;
        end
        if (op_q[1]) begin
            if (b_q == '0) begin
                hi_res_c = a_q;
                lo_res_c = '1;
            end else begin
                hi_res_c = (!op_q[0] && sign_a) ? -acc[2*DATA_W-1:DATA_W]
                                                : acc[2*DATA_W-1:DATA_W];
                lo_res_c = (!op_q[0] && (sign_a ^ sign_b)) ? -acc[DATA_W-1:0]
                                                           : acc[DATA_W-1:0];
            end
        end else begin
            {hi_res_c, lo_res_c} = prod_c;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        iter_c   = 1'b0;
        finish_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
`ifdef MULDIV_EARLY_EXIT_EN
                    state_d  = (b == '0) ? FIX : RUN;
`else
                    state_d  = RUN;
`endif
                end
            end
            RUN: begin
                iter_c = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                finish_c = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= finish_c;
            div_by_zero <= finish_c & op_q[1] & (b_q == '0);
            if (accept_c) begin
                op_q   <= op;
                sign_a <= a_neg_c;
                sign_b <= b_neg_c;
                a_q    <= a;
                b_q    <= b_abs_c;
                acc    <= {DATA_W'(0), a_abs_c};
                cnt    <= '0;
                busy   <= 1'b1;
            end
            if (iter_c) begin
                acc <= op_q[1] ? div_next_c : mul_next_c;
                cnt <= cnt + CNT_W'(1);
            end
            if (finish_c) begin
                hi   <= hi_res_c;
                lo   <= lo_res_c;
                busy <= 1'b0;
            end else if (!busy) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0] p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: begin
                p = sx * sy;
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, x} * {32'b0, y};
                return {1'b0, p};
            end
            2'b10: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Issue one operation and follow it to completion. poke>=0 drives a stray
    // start plus MTHI/MTLO at that busy cycle; mt issues MTHI on the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input int poke, input bit mt);
        logic [64:0] r;
        int n;
        int exp_cyc;
        r = model(o, va, vb);
        exp_cyc = 33;
`ifdef MULDIV_EARLY_EXIT_EN
        if (vb == 0) exp_cyc = 1;
`endif
        op = o;
        a = va;
        b = vb;
        start = 1'b1;
        if (mt) begin
            hi_we = 1'b1;
            wdata = va ^ 32'hA5A5_0000;
            hi_m = wdata;
        end
        @(posedge clk); #1;
        start = 1'b0;
        hi_we = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 0) begin
                check("hold_hi", 64'(hi), 64'(hi_m));
                check("hold_lo", 64'(lo), 64'(lo_m));
            end
            if (n == poke) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'h1234;
                op = ~o;
            end
            if (n == poke + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_cycles", 64'(n), 64'(exp_cyc));
        hi_m = r[63:32];
        lo_m = r[31:0];
        check("done_rise", 64'(done), 64'd1);
        check("div_by_zero", 64'(div_by_zero), 64'(r[64]));
        check("hi", 64'(hi), 64'(hi_m));
        check("lo", 64'(lo), 64'(lo_m));
        @(posedge clk); #1;
        check("done_fall", 64'(done), 64'd0);
        check("dz_fall", 64'(div_by_zero), 64'd0);
    endtask

    task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d);
        hi_we = hw;
        lo_we = lw;
        wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) hi_m = d;
        if (lw) lo_m = d;
        check("mt_hi", 64'(hi), 64'(hi_m));
        check("mt_lo", 64'(lo), 64'(lo_m));
        check("mt_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b0;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #2 reset = 1'b1;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, -1, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'd0, -1, 1'b0);

        // Stray start/MTHI/MTLO while busy are ignored
        run_op(2'b11, 32'd100, 32'd7, 5, 1'b0);
        mt_write(1'b1, 1'b0, 32'h1234);
        mt_write(1'b0, 1'b1, 32'h0BAD_BEEF);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        run_op(2'b01, 32'd9, 32'd11, -1, 1'b1);

        // Asynchronous reset in the middle of a MULT
        op = 2'b00;
        a = 32'hFFFF_0003;
        b = 32'd77;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        hi_m = '0;
        lo_m = '0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        run_op(2'b01, 32'd3, 32'd4, -1, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, -1, 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for MIPS MULT, MULTU, DIV and DIVU, sitting in the execute stage directly downstream of the register file. It consumes the register file's two read operands (rs, rt) and holds results in architectural HI/LO registers. MFHI/MFLO write HI/LO back to the register file's write port; MTHI/MTLO load them directly. Multi-cycle: the control path stalls on busy.

Parameters:
DATA_W, 32, operand width and HI/LO width; only 32 is verified.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request an operation; sampled only while busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  DATA_W  operand A (rs read data)
b  input  DATA_W  operand B (rt read data)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  DATA_W  MTHI/MTLO data (rs read data)
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO hold a new result
div_by_zero  output  1  pulses with done when a DIV/DIVU had b=0
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register

Behaviour:
- Reset, asynchronous and usable at any time, including mid-operation: FSM goes to IDLE; counter, busy, done, div_by_zero, hi and lo all go to 0. The in-flight operation is discarded.
- FSM states and transitions:
  - IDLE: moves to RUN on an edge with start=1.
  - RUN: runs exactly DATA_W iterations, one per edge, then moves to FIX.
  - FIX: on the next edge, writes hi/lo and returns to IDLE.
- Timing, with edge k = the edge where start is accepted:
  - Edge k captures op, the absolute values of a and b (signed ops only), and the sign bits.
  - busy is high from edge k to edge k+33 (33 cycles).
  - Edges k+1..k+32 perform the iterations.
  - Edge k+33 writes hi/lo and drops busy; done is high for the single cycle after edge k+33.
- Multiply: unsigned shift-add over DATA_W iterations into a 2*DATA_W product. For MULT, the product is negated when sign(a)^sign(b). Result: {hi,lo} = product.
- Divide: restoring division, one quotient bit per iteration. Result: lo = quotient, hi = remainder.
  - DIV: quotient is negated when sign(a)^sign(b); remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b=0 on DIV/DIVU): normal latency; result lo=0xFFFFFFFF, hi=a (raw operand); div_by_zero pulses with done.
- start while busy=1 is ignored (no queueing). The control path must hold start until busy=0.
- hi_we/lo_we:
  - Honoured only while busy=0, and ignored while busy=1.
  - hi_we and start on the same IDLE edge: the MTHI/MTLO write takes effect, then the operation result overwrites it at edge k+33.
  - hi_we and lo_we on the same edge: both registers are written with wdata.
- hi/lo are stable and readable at all times except on the result-write edge. Reading during busy returns the previous values.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined: if b=0 at edge k (any op), the FSM goes IDLE→FIX directly and skips RUN. hi/lo are written at edge k+1; busy is high 1 cycle; done is high the cycle after edge k+1. Results are the same as the full-latency path: MULT/MULTU give hi=lo=0; DIV/DIVU give the divide-by-zero values above.
- Undefined: every operation takes the fixed 33-cycle latency.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles; done one cycle.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
4. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done; with MULDIV_EARLY_EXIT_EN, busy lasts 1 cycle.
5. Start DIVU, pulse start again and hi_we=1 wdata=0x1234 at cycle 5 -> both ignored; original result delivered at edge k+33. hi_we in IDLE -> hi=0x1234 next edge, lo unchanged.
6. Assert reset at cycle 10 of a MULT -> busy, done, hi, lo go to 0 immediately with no clock edge needed. A new MULTU 3*4 after deassertion -> lo=12, hi=0.
